// File: rtl/mult_sched_if.sv
// Requester-side bus of mult_sched: per-requester operands, grant/done handshake, product.
interface mult_sched_if #(
  parameter int unsigned WIDTH = 8
);
  logic [1:0]         req;
  logic [WIDTH-1:0]   opa0;
  logic [WIDTH-1:0]   opa1;
  logic [WIDTH-1:0]   opb0;
  logic [WIDTH-1:0]   opb1;
  logic [1:0]         gnt;
  logic [1:0]         done;
  logic [2*WIDTH-1:0] product;
  logic               busy;

  modport master (output req, opa0, opa1, opb0, opb1,
                  input  gnt, done, product, busy);
  modport slave  (input  req, opa0, opa1, opb0, opb1,
                  output gnt, done, product, busy);
endinterface

// File: rtl/mult_sched.sv
// Two-requester arbiter/sequencer for a shared add-shift signed multiplier datapath.
// Optional feature: define MULT_SCHED_ZERO_SKIP_EN to short-cut operations with a zero operand.
module mult_sched #(
  parameter int unsigned WIDTH = 8
) (
  input  logic                 Clk,
  input  logic                 Reset_n,
  mult_sched_if.slave          bus,
  output logic [WIDTH-1:0]     dp_S,
  output logic [WIDTH-1:0]     dp_B,
  output logic                 Clr_Ld,
  output logic                 Add,
  output logic                 Fn,
  output logic                 Shift_En,
  input  logic                 M,
  input  logic [2*WIDTH-1:0]   dp_prod
);
  localparam int unsigned PW = 2 * WIDTH;
  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [2:0] {IDLE, LOAD, ADD, SHIFT, DONE} state_t;

  state_t            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              last_q, last_d;
  logic [1:0]        gnt_q, gnt_d;
  logic [1:0]        done_q, done_d;
  logic [PW-1:0]     prod_q, prod_d;
  logic              busy_q, busy_d;
  logic [WIDTH-1:0]  s_q, s_d;
  logic [WIDTH-1:0]  b_q, b_d;
  logic              clr_q, clr_d;
  logic              add_q, add_d;
  logic              fn_q, fn_d;
  logic              shf_q, shf_d;
  logic              skip_q, skip_d;
  logic              win;
  logic [PW-1:0]     prod_now;

  // Product source during DONE: the datapath's final {A,B}, or zero for a skipped operation
  assign prod_now = skip_q ? '0 : dp_prod;

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      last_q  <= 1'b1;
      gnt_q   <= '0;
      done_q  <= '0;
      prod_q  <= '0;
      busy_q  <= 1'b0;
      s_q     <= '0;
      b_q     <= '0;
      clr_q   <= 1'b0;
      add_q   <= 1'b0;
      fn_q    <= 1'b0;
      shf_q   <= 1'b0;
      skip_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      last_q  <= last_d;
      gnt_q   <= gnt_d;
      done_q  <= done_d;
      prod_q  <= prod_d;
      busy_q  <= busy_d;
      s_q     <= s_d;
      b_q     <= b_d;
      clr_q   <= clr_d;
      add_q   <= add_d;
      fn_q    <= fn_d;
      shf_q   <= shf_d;
      skip_q  <= skip_d;
    end
  end

  // Next state plus next values of the registered strobes for the state being entered
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    last_d  = last_q;
    gnt_d   = gnt_q;
    done_d  = '0;
    prod_d  = prod_q;
    busy_d  = 1'b0;
    s_d     = s_q;
    b_d     = b_q;
    clr_d   = 1'b0;
    add_d   = 1'b0;
    fn_d    = 1'b0;
    shf_d   = 1'b0;
    skip_d  = skip_q;
    win     = 1'b0;

    case (state_q)
      IDLE: begin
        if (|bus.req) begin
          win     = (bus.req == 2'b11) ? ~last_q : bus.req[1];
          s_d     = win ? bus.opa1 : bus.opa0;
          b_d     = win ? bus.opb1 : bus.opb0;
          gnt_d   = win ? 2'b10 : 2'b01;
          skip_d  = 1'b0;
          clr_d   = 1'b1;
          state_d = LOAD;
        end
      end
      LOAD: begin
        cnt_d   = '0;
        add_d   = 1'b1;
        fn_d    = (cnt_d == LAST);
        state_d = ADD;
`ifdef MULT_SCHED_ZERO_SKIP_EN
        if ((s_q == '0) || (b_q == '0)) begin
          add_d   = 1'b0;
          fn_d    = 1'b0;
          skip_d  = 1'b1;
          done_d  = gnt_q;
          state_d = DONE;
        end
`endif
      end
      ADD: begin
        shf_d   = 1'b1;
        state_d = SHIFT;
      end
      SHIFT: begin
        if (cnt_q == LAST) begin
          done_d  = gnt_q;
          state_d = DONE;
        end else begin
          cnt_d   = cnt_q + CW'(1);
          add_d   = 1'b1;
          fn_d    = (cnt_d == LAST);
          state_d = ADD;
        end
      end
      DONE: begin
        prod_d  = prod_now;
        last_d  = gnt_q[1];
        gnt_d   = '0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  // Add follows the live multiplier bit M while in ADD; everything else is a flop output
  assign Add         = add_q & M;
  assign Fn          = fn_q;
  assign Clr_Ld      = clr_q;
  assign Shift_En    = shf_q;
  assign dp_S        = s_q;
  assign dp_B        = b_q;
  assign bus.gnt     = gnt_q;
  assign bus.done    = done_q;
  assign bus.busy    = busy_q;
  assign bus.product = (state_q == DONE) ? prod_now : prod_q;
endmodule

// File: tb/tb_mult_sched.sv
// Randomized scoreboard bench for mult_sched with a behavioural add-shift datapath model.
module tb_mult_sched;
  localparam int unsigned W  = 8;
  localparam int unsigned PW = 2 * W;
  localparam int FULL_LAT    = 2 * W + 2;
`ifdef MULT_SCHED_ZERO_SKIP_EN
  localparam bit SKIP_EN = 1'b1;
`else
  localparam bit SKIP_EN = 1'b0;
`endif

  logic Clk = 1'b0;
  logic Reset_n = 1'b0;
  logic [W-1:0]  dp_S, dp_B;
  logic          Clr_Ld, Add, Fn, Shift_En, M;
  logic [PW-1:0] dp_prod;

  mult_sched_if #(.WIDTH(W)) bus ();

  mult_sched #(.WIDTH(W)) dut (
    .Clk(Clk), .Reset_n(Reset_n), .bus(bus),
    .dp_S(dp_S), .dp_B(dp_B), .Clr_Ld(Clr_Ld), .Add(Add), .Fn(Fn),
    .Shift_En(Shift_En), .M(M), .dp_prod(dp_prod)
  );

  always #5 Clk = ~Clk;

  int cyc = 0;
  always @(posedge Clk) cyc <= cyc + 1;

  // Shared datapath: A, X, B registers with a 9-bit adder/subtractor
  logic [W-1:0] a_r = '0;
  logic [W-1:0] b_r = '0;
  logic         x_r = 1'b0;
  logic [W:0]   dp_sum;
  assign dp_sum = Fn ? ({a_r[W-1], a_r} - {dp_S[W-1], dp_S})
                     : ({a_r[W-1], a_r} + {dp_S[W-1], dp_S});
  always @(posedge Clk) begin
    if (Clr_Ld) begin
      a_r <= '0;
      x_r <= 1'b0;
      b_r <= dp_B;
    end else if (Add) begin
      {x_r, a_r} <= dp_sum;
    end else if (Shift_En) begin
      {x_r, a_r, b_r} <= {x_r, x_r, a_r, b_r[W-1:1]};
    end
  end
  assign M       = b_r[0];
  assign dp_prod = {a_r, b_r};

  typedef struct {
    logic [1:0]    onehot;
    logic [PW-1:0] prod;
    int            due;
    int            adds;
    int            shifts;
  } exp_t;

  exp_t sbq[$];
  int   checks = 0;
  int   passes = 0;
  bit   model_last = 1'b1;
  int   add_cnt = 0;
  int   shf_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act === req) passes++;
    else $display("FAIL %s: got 0x%0h, wanted 0x%0h (cycle %0d)", name, act, req, cyc);
  endtask

  function automatic logic [PW-1:0] ref_mul(input logic [W-1:0] a, input logic [W-1:0] b);
    int sa, sb;
    sa = int'($signed(a));
    sb = int'($signed(b));
    return PW'(sa * sb);
  endfunction

  function automatic bit skipped(input logic [W-1:0] a, input logic [W-1:0] b);
    return SKIP_EN && ((a == '0) || (b == '0));
  endfunction

  function automatic int lat(input logic [W-1:0] a, input logic [W-1:0] b);
    return skipped(a, b) ? 2 : FULL_LAT;
  endfunction

  function automatic logic [1:0] onehot(input int r);
    return (r == 1) ? 2'b10 : 2'b01;
  endfunction

  function automatic logic [W-1:0] rnd_op();
    return ($urandom_range(0, 7) == 0) ? '0 : W'($urandom);
  endfunction

  task automatic push(input int r, input logic [W-1:0] a, input logic [W-1:0] b, input int due);
    exp_t e;
    e.onehot = onehot(r);
    e.prod   = ref_mul(a, b);
    e.due    = due;
    e.adds   = skipped(a, b) ? 0 : $countones(b);
    e.shifts = skipped(a, b) ? 0 : int'(W);
    sbq.push_back(e);
  endtask

  task automatic set_ops(input int r, input logic [W-1:0] a, input logic [W-1:0] b);
    if (r == 0) begin bus.opa0 = a; bus.opb0 = b; end
    else        begin bus.opa1 = a; bus.opb1 = b; end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_gnt"},     32'(bus.gnt), 32'd0);
    chk({tag, "_done"},    32'(bus.done), 32'd0);
    chk({tag, "_busy"},    32'(bus.busy), 32'd0);
    chk({tag, "_product"}, 32'(bus.product), 32'd0);
    chk({tag, "_dp_ops"},  32'({dp_S, dp_B}), 32'd0);
    chk({tag, "_strobes"}, 32'({Clr_Ld, Add, Fn, Shift_En}), 32'd0);
  endtask

  // Monitor: strobe exclusivity, pulse counting, and scoreboard pops on every done pulse
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge Clk);
      if (!Reset_n) continue;
      if (Clr_Ld) begin
        add_cnt = 0;
        shf_cnt = 0;
      end else begin
        add_cnt += int'(Add);
        shf_cnt += int'(Shift_En);
      end
      if (Clr_Ld | Add | Shift_En)
        chk("strobe_exclusive", 32'($countones({Clr_Ld, Add, Shift_En})), 32'd1);
      if (bus.done != 2'b00) begin
        if (sbq.size() == 0) begin
          chk("unexpected_done", 32'(bus.done), 32'd0);
        end else begin
          e = sbq.pop_front();
          chk("done_who",     32'(bus.done), 32'(e.onehot));
          chk("done_gnt",     32'(bus.gnt), 32'(e.onehot));
          chk("product",      32'(bus.product), 32'(e.prod));
          chk("done_cycle",   32'(cyc), 32'(e.due));
          chk("add_pulses",   32'(add_cnt), 32'(e.adds));
          chk("shift_pulses", 32'(shf_cnt), 32'(e.shifts));
        end
      end
    end
  end

  task automatic single_op(input int r, input logic [W-1:0] a, input logic [W-1:0] b,
                           input int drop, input bit scramble);
    int s, l;
    bit seen;
    seen = 1'b0;
    @(negedge Clk);
    set_ops(r, a, b);
    bus.req[r] = 1'b1;
    s = cyc;
    l = lat(a, b);
    push(r, a, b, s + l);
    for (int k = 0; k < l + 20 && !seen; k++) begin
      @(negedge Clk);
      if (cyc == s + 1) begin
        chk("gnt_at_load", 32'(bus.gnt), 32'(onehot(r)));
        chk("clr_at_load", 32'(Clr_Ld), 32'd1);
        chk("busy_at_load", 32'(bus.busy), 32'd1);
        if (scramble) set_ops(r, W'($urandom), W'($urandom));
      end
      if (l == FULL_LAT && cyc == s + FULL_LAT - 2) begin
        chk("fn_last_add", 32'(Fn), 32'd1);
        chk("add_last_bit", 32'(Add), 32'(b[W-1]));
      end
      if (drop > 0 && cyc == s + drop) bus.req[r] = 1'b0;
      if (bus.done[r]) seen = 1'b1;
    end
    chk("done_seen", 32'(seen), 32'd1);
    bus.req[r] = 1'b0;
    model_last = r[0];
    @(negedge Clk);
    chk("busy_after_done", 32'(bus.busy), 32'd0);
    chk("product_held", 32'(bus.product), 32'(ref_mul(a, b)));
  endtask

  task automatic dual_op(input logic [W-1:0] a0, input logic [W-1:0] b0,
                         input logic [W-1:0] a1, input logic [W-1:0] b1);
    logic [W-1:0] oa[2];
    logic [W-1:0] ob[2];
    int s, w, l, dw, dl;
    bit seen_w, seen_l;
    oa[0] = a0; ob[0] = b0; oa[1] = a1; ob[1] = b1;
    seen_w = 1'b0;
    seen_l = 1'b0;
    @(negedge Clk);
    set_ops(0, a0, b0);
    set_ops(1, a1, b1);
    bus.req = 2'b11;
    s  = cyc;
    w  = model_last ? 0 : 1;
    l  = 1 - w;
    dw = s + lat(oa[w], ob[w]);
    dl = dw + 1 + lat(oa[l], ob[l]);
    push(w, oa[w], ob[w], dw);
    push(l, oa[l], ob[l], dl);
    for (int k = 0; k < dl - s + 20 && !seen_l; k++) begin
      @(negedge Clk);
      if (cyc == s + 1)  chk("tie_first_gnt", 32'(bus.gnt), 32'(onehot(w)));
      if (cyc == dw + 2) chk("tie_second_gnt", 32'(bus.gnt), 32'(onehot(l)));
      if (bus.done[w]) begin bus.req[w] = 1'b0; seen_w = 1'b1; end
      if (bus.done[l]) begin bus.req[l] = 1'b0; seen_l = 1'b1; end
    end
    chk("tie_done_first", 32'(seen_w), 32'd1);
    chk("tie_done_second", 32'(seen_l), 32'd1);
    bus.req = 2'b00;
    model_last = l[0];
  endtask

  task automatic reset_mid(input logic [W-1:0] a0, input logic [W-1:0] b0,
                           input logic [W-1:0] a1, input logic [W-1:0] b1);
    int s;
    bit seen;
    seen = 1'b0;
    @(negedge Clk);
    set_ops(0, a0, b0);
    bus.req = 2'b01;
    s = cyc;
    for (int k = 0; k < 20 && cyc < s + 10; k++) @(negedge Clk);
    Reset_n = 1'b0;
    #1;
    chk_all_zero("mid_reset");
    set_ops(1, a1, b1);
    bus.req = 2'b10;
    model_last = 1'b1;
    repeat (2) @(negedge Clk);
    Reset_n = 1'b1;
    s = cyc;
    push(1, a1, b1, s + lat(a1, b1));
    for (int k = 0; k < FULL_LAT + 20 && !seen; k++) begin
      @(negedge Clk);
      if (bus.done[1]) seen = 1'b1;
    end
    chk("restart_done_seen", 32'(seen), 32'd1);
    bus.req = 2'b00;
    model_last = 1'b1;
    @(negedge Clk);
    chk("restart_product_held", 32'(bus.product), 32'(ref_mul(a1, b1)));
  endtask

  initial begin : stimulus
    int mode;
    logic [W-1:0] ra0, rb0, ra1, rb1;
    bus.req  = 2'b00;
    bus.opa0 = '0; bus.opb0 = '0;
    bus.opa1 = '0; bus.opb1 = '0;
    repeat (3) @(negedge Clk);
    chk_all_zero("reset");
    Reset_n = 1'b1;

    dual_op(8'h11, 8'h05, 8'hF3, 8'h7A);
    dual_op(8'h9C, 8'h3D, 8'h40, 8'hFF);
    single_op(0, 8'd7,  8'd3,  0, 1'b0);
    single_op(0, 8'hFE, 8'h05, 0, 1'b0);
    single_op(0, 8'h02, 8'h80, 0, 1'b0);
    single_op(0, 8'h80, 8'h80, 0, 1'b0);
    single_op(1, 8'h7F, 8'h81, 0, 1'b0);
    single_op(0, 8'h6B, 8'hC4, 5, 1'b1);
    single_op(0, 8'h00, 8'h55, 0, 1'b0);
    single_op(1, 8'h37, 8'h00, 0, 1'b0);
    reset_mid(8'h5A, 8'hA5, 8'hE1, 8'h0D);

    for (int n = 0; n < 30; n++) begin
      mode = int'($urandom_range(0, 2));
      ra0 = rnd_op(); rb0 = rnd_op();
      ra1 = rnd_op(); rb1 = rnd_op();
      if (mode == 2) dual_op(ra0, rb0, ra1, rb1);
      else single_op(mode, (mode == 0) ? ra0 : ra1, (mode == 0) ? rb0 : rb1,
                     ($urandom_range(0, 3) == 0) ? int'($urandom_range(2, 12)) : 0, 1'b1);
    end

    repeat (5) @(negedge Clk);
    chk("scoreboard_drained", 32'(sbq.size()), 32'd0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1);
  end
endmodule
